// File: rtl/nanov_serial_regfile_if.sv
// Bus bundle for the digit-serial register file: controller side (master)
// drives selects, write data and run; the register file (slave) returns digits.
interface nanov_serial_regfile_if #(
  parameter int AW = 4,
  parameter int DW = 1,
  parameter int CW = 5
) ();
  logic          run;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [AW-1:0] rd;
  logic          wr_en;
  logic          wr_next_en;
  logic          read_through;
  logic [DW-1:0] data_rd;
  logic [DW-1:0] data_rd_next;
  logic [DW-1:0] data_rs1;
  logic [DW-1:0] data_rs2;
  logic [CW-1:0] digit_idx;
  logic          last_digit;

  modport master (
    output run, rs1, rs2, rd, wr_en, wr_next_en, read_through, data_rd, data_rd_next,
    input  data_rs1, data_rs2, digit_idx, last_digit
  );

  modport slave (
    input  run, rs1, rs2, rd, wr_en, wr_next_en, read_through, data_rd, data_rd_next,
    output data_rs1, data_rs2, digit_idx, last_digit
  );
endinterface

// File: rtl/nanov_serial_regfile.sv
// Digit-serial register file: every register is a circular store of ND digits
// visited LSB-first by a shared digit counter, with one-cycle next-digit forwarding.
module nanov_serial_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 16,
  parameter int DW   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  nanov_serial_regfile_if.slave  bus
);
  localparam int ND = XLEN / DW;
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(ND);

  logic [XLEN-1:0] r_regs [NREG];
  logic [CW-1:0]   r_cnt;
  logic            r_lt;
  logic [AW-1:0]   r_lrd;
  logic [DW-1:0]   r_lnext;

  logic            w_last;
  logic [CW-1:0]   w_cnt_next;
  logic [DW-1:0]   w_rs1;
  logic [DW-1:0]   w_rs2;

  function automatic logic [DW-1:0] digit_of(input logic [XLEN-1:0] word,
                                             input logic [CW-1:0]   idx);
    return word[idx*DW +: DW];
  endfunction

  // x0 always reads zero; a pending read-through for a nonzero rd beats storage.
  function automatic logic [DW-1:0] port_data(input logic [AW-1:0]   rs,
                                              input logic [DW-1:0]   stored,
                                              input logic            lt,
                                              input logic [AW-1:0]   lrd,
                                              input logic [DW-1:0]   lnext);
    if (rs == '0)
      return '0;
    if (lt && (lrd != '0) && (rs == lrd))
      return lnext;
    return stored;
  endfunction

  assign w_last     = (r_cnt == CW'(ND - 1));
  assign w_cnt_next = w_last ? '0 : r_cnt + CW'(1);

  always_comb begin
    w_rs1 = port_data(bus.rs1, digit_of(r_regs[bus.rs1], r_cnt), r_lt, r_lrd, r_lnext);
    w_rs2 = port_data(bus.rs2, digit_of(r_regs[bus.rs2], r_cnt), r_lt, r_lrd, r_lnext);
  end

  assign bus.data_rs1   = w_rs1;
  assign bus.data_rs2   = w_rs2;
  assign bus.digit_idx  = r_cnt;
  assign bus.last_digit = w_last;

  // ---- storage, digit counter and read-through capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
      r_cnt   <= '0;
      r_lt    <= 1'b0;
      r_lrd   <= '0;
      r_lnext <= '0;
    end else if (bus.run) begin
      // Current and next digit never alias because ND >= 4.
      if (bus.rd != '0) begin
        if (bus.wr_en)
          r_regs[bus.rd][r_cnt*DW +: DW] <= bus.data_rd;
        if (bus.wr_next_en)
          r_regs[bus.rd][w_cnt_next*DW +: DW] <= bus.data_rd_next;
      end
      r_cnt   <= w_cnt_next;
      r_lt    <= bus.read_through;
      r_lrd   <= bus.rd;
      r_lnext <= bus.data_rd_next;
    end
  end
endmodule

// File: tb/tb_nanov_serial_regfile.sv
// Self-checking bench: DW=1 instance against a word-level model plus a
// forwarding vector table; a DW=4 instance for next-digit wrap writes.
module tb_nanov_serial_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nanov_serial_regfile_if #(.AW(4), .DW(1), .CW(5)) ifa ();
  nanov_serial_regfile_if #(.AW(4), .DW(4), .CW(3)) ifb ();

  nanov_serial_regfile #(.XLEN(32), .NREG(16), .DW(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  nanov_serial_regfile #(.XLEN(32), .NREG(16), .DW(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_cmp  = 0;
  int n_fail = 0;

  // Word-level reference for the DW=1 instance.
  logic [31:0] m_mem [16];
  int          m_c;
  bit          m_lt;
  int          m_lrd;
  bit          m_lnext;

  typedef struct {
    bit rt;
    int rd;
    bit dn;
    int rs1;
    int rs2;
    bit e1;
    bit e2;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_c = 0; m_lt = 0; m_lrd = 0; m_lnext = 0;
  endtask

  function automatic logic exp_a(input int rs);
    if (rs == 0) return 1'b0;
    if (m_lt && m_lrd != 0 && rs == m_lrd) return m_lnext;
    return m_mem[rs][m_c];
  endfunction

  task automatic model_edge_a();
    if (ifa.run) begin
      if (ifa.rd != 0) begin
        if (ifa.wr_en)      m_mem[ifa.rd][m_c]          = ifa.data_rd;
        if (ifa.wr_next_en) m_mem[ifa.rd][(m_c + 1) % 32] = ifa.data_rd_next;
      end
      m_lt    = ifa.read_through;
      m_lrd   = int'(ifa.rd);
      m_lnext = ifa.data_rd_next;
      m_c     = (m_c + 1) % 32;
    end
  endtask

  task automatic check_model_a(input string tag);
    check({tag, "_rs1"},  ifa.data_rs1,   exp_a(int'(ifa.rs1)));
    check({tag, "_rs2"},  ifa.data_rs2,   exp_a(int'(ifa.rs2)));
    check({tag, "_idx"},  ifa.digit_idx,  m_c);
    check({tag, "_last"}, ifa.last_digit, (m_c == 31));
  endtask

  task automatic drive_a(input bit run, input int rs1, input int rs2, input int rd,
                         input bit we, input bit wne, input bit rt, input bit d, input bit dn);
    @(negedge clk);
    ifa.run = run; ifa.rs1 = 4'(rs1); ifa.rs2 = 4'(rs2); ifa.rd = 4'(rd);
    ifa.wr_en = we; ifa.wr_next_en = wne; ifa.read_through = rt;
    ifa.data_rd = d; ifa.data_rd_next = dn;
    #1;
  endtask

  task automatic edge_a();
    @(posedge clk);
    model_edge_a();
  endtask

  task automatic drive_b(input bit run, input int rs1, input int rd, input bit wne, input int dn);
    @(negedge clk);
    ifb.run = run; ifb.rs1 = 4'(rs1); ifb.rs2 = 4'd0; ifb.rd = 4'(rd);
    ifb.wr_en = 1'b0; ifb.wr_next_en = wne; ifb.read_through = 1'b0;
    ifb.data_rd = 4'd0; ifb.data_rd_next = 4'(dn);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] word;
    int lastcnt;
    int lastpos;

    ifa.run = 0; ifa.rs1 = 4'd5; ifa.rs2 = 4'd3; ifa.rd = 0; ifa.wr_en = 0; ifa.wr_next_en = 0;
    ifa.read_through = 0; ifa.data_rd = 0; ifa.data_rd_next = 0;
    ifb.run = 0; ifb.rs1 = 0; ifb.rs2 = 0; ifb.rd = 0; ifb.wr_en = 0; ifb.wr_next_en = 0;
    ifb.read_through = 0; ifb.data_rd = 0; ifb.data_rd_next = 0;
    model_reset();

    vt[0] = '{rt:1, rd:7, dn:1, rs1:7, rs2:0, e1:0, e2:0};
    vt[1] = '{rt:0, rd:0, dn:0, rs1:7, rs2:0, e1:1, e2:0};
    vt[2] = '{rt:1, rd:0, dn:1, rs1:7, rs2:7, e1:0, e2:0};
    vt[3] = '{rt:0, rd:0, dn:0, rs1:7, rs2:0, e1:0, e2:0};
    vt[4] = '{rt:1, rd:5, dn:1, rs1:5, rs2:5, e1:0, e2:0};
    vt[5] = '{rt:0, rd:0, dn:0, rs1:5, rs2:5, e1:1, e2:1};
    vt[6] = '{rt:1, rd:5, dn:1, rs1:0, rs2:5, e1:0, e2:0};
    vt[7] = '{rt:0, rd:0, dn:0, rs1:0, rs2:5, e1:0, e2:1};

    // Reset held across an edge: everything reads zero.
    #12;
    check("rst_rs1",  ifa.data_rs1,   0);
    check("rst_rs2",  ifa.data_rs2,   0);
    check("rst_idx",  ifa.digit_idx,  0);
    check("rst_last", ifa.last_digit, 0);
    @(negedge clk);
    rst = 1'b0;

    // DW=4: next-digit writes starting at c=7 wrap into digit 0.
    for (int i = 0; i < 7; i++) begin drive_b(1, 0, 0, 0, 0); @(posedge clk); end
    drive_b(0, 0, 0, 0, 0);
    check("b_idx7",  ifb.digit_idx,  7);
    check("b_last7", ifb.last_digit, 1);
    for (int k = 1; k <= 8; k++) begin drive_b(1, 0, 3, 1, k); @(posedge clk); end
    drive_b(1, 0, 0, 0, 0); @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      drive_b(1, 3, 0, 0, 0);
      check("b_x3_digit", ifb.data_rs1,   k + 1);
      check("b_x3_idx",   ifb.digit_idx,  k);
      check("b_x3_last",  ifb.last_digit, (k == 7));
      @(posedge clk);
    end
    drive_b(0, 0, 0, 0, 0);

    // Serial write of x5 from c=0, then serial read-back.
    word = 32'hA5A5_0F0F;
    for (int i = 0; i < 32; i++) begin
      drive_a(1, 5, 0, 5, 1, 0, 0, word[i], 0);
      check_model_a("wr_x5");
      edge_a();
    end
    lastcnt = 0; lastpos = -1;
    for (int i = 0; i < 32; i++) begin
      drive_a(1, 5, 0, 0, 0, 0, 0, 0, 0);
      check("x5_serial", ifa.data_rs1, word[i]);
      check_model_a("rd_x5");
      if (ifa.last_digit) begin lastcnt++; lastpos = i; end
      edge_a();
    end
    check("last_cnt", lastcnt, 1);
    check("last_pos", lastpos, 31);

    // Forwarding vectors, starting at c=0 with no pending read-through.
    for (int i = 0; i < 8; i++) begin
      drive_a(1, vt[i].rs1, vt[i].rs2, vt[i].rd, 0, 0, vt[i].rt, 0, vt[i].dn);
      check($sformatf("fwd%0d_rs1", i), ifa.data_rs1,  vt[i].e1);
      check($sformatf("fwd%0d_rs2", i), ifa.data_rs2,  vt[i].e2);
      check($sformatf("fwd%0d_idx", i), ifa.digit_idx, i);
      edge_a();
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int r1;
      int rdv;
      r1  = $urandom_range(0, 15);
      rdv = ($urandom_range(0, 3) == 0) ? r1 : $urandom_range(0, 15);
      drive_a($urandom_range(0, 3) != 0, r1, $urandom_range(0, 15), rdv,
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1));
      check_model_a("rand");
      edge_a();
    end

    // x9 all ones, pause at c=12 with a zero write pending, then resume.
    for (int i = 0; i < 32; i++) begin drive_a(1, 9, 0, 9, 1, 0, 0, 1, 0); check_model_a("wr_x9"); edge_a(); end
    for (int g = 0; g < 32 && m_c != 12; g++) begin
      drive_a(1, 9, 0, 0, 0, 0, 0, 0, 0); check_model_a("seek"); edge_a();
    end
    for (int i = 0; i < 5; i++) begin
      drive_a(0, 9, 9, 9, 1, 1, 1, 0, 0);
      check("pause_idx", ifa.digit_idx, 12);
      check("pause_x9",  ifa.data_rs1,  1);
      check_model_a("pause");
      edge_a();
    end
    for (int i = 0; i < 32; i++) begin
      drive_a(1, 9, 0, 0, 0, 0, 0, 0, 0);
      check("resume_idx", ifa.digit_idx, (12 + i) % 32);
      check("resume_x9",  ifa.data_rs1,  1);
      edge_a();
    end

    // Writes to x0 are discarded; scan every register afterwards.
    for (int i = 0; i < 32; i++) begin
      drive_a(1, 0, 0, 0, 1, 1, 1, 1, 1);
      check("x0_zero", ifa.data_rs1, 0);
      check_model_a("x0");
      edge_a();
    end
    for (int r = 1; r < 16; r++)
      for (int i = 0; i < 32; i++) begin
        drive_a(1, r, r, 0, 0, 0, 0, 0, 0); check_model_a("scan"); edge_a();
      end

    // Reset in the middle of rewriting x2.
    for (int i = 0; i < 32; i++) begin drive_a(1, 2, 0, 2, 1, 0, 0, 1, 0); edge_a(); end
    for (int g = 0; g < 32 && m_c != 17; g++) begin
      drive_a(1, 2, 2, 2, 1, 0, 0, 0, 0); check_model_a("pre_rst"); edge_a();
    end
    drive_a(1, 2, 2, 2, 1, 1, 1, 0, 1);
    check("pre_rst_idx", ifa.digit_idx, 17);
    #2 rst = 1'b1;
    #1;
    check("arst_rs1",  ifa.data_rs1,   0);
    check("arst_rs2",  ifa.data_rs2,   0);
    check("arst_idx",  ifa.digit_idx,  0);
    check("arst_last", ifa.last_digit, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_idx", ifa.digit_idx, 0);
    ifa.run = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive_a(1, 2, 9, 0, 0, 0, 0, 0, 0);
      check("post_rst_x2", ifa.data_rs1, 0);
      check_model_a("post_rst");
      edge_a();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
